// File: rtl/program_memory_loader.sv
// Byte-stream program loader: 16-bit LE word count, then 4-byte LE words written to program memory.
// Define LOADER_CHECKSUM_EN to add a trailing XOR checksum byte verified in a CHECK state.
module program_memory_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
`endif
        FINISH
    } state_t;

    localparam logic [16:0] DEPTH_LIM = 17'(MEMORY_DEPTH);

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           index_q, index_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           word_q, word_d;
    logic [DATA_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  error_q, error_d;
    logic [15:0]           len_full;
    logic                  xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            cksum_q, cksum_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            index_q       <= '0;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            error_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cksum_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            index_q       <= index_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            error_q       <= error_d;
`ifdef LOADER_CHECKSUM_EN
            cksum_q       <= cksum_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        index_d       = index_q;
        byte_cnt_d    = byte_cnt_q;
        word_d        = word_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        error_d       = error_q;
        len_full      = {byte_data, len_q[7:0]};
        xfer          = byte_valid && byte_ready;
`ifdef LOADER_CHECKSUM_EN
        cksum_d       = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LEN_LO;
                    error_d    = 1'b0;
                    index_d    = '0;
                    byte_cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    cksum_d    = '0;
`endif
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = FINISH;
                    end else if ({1'b0, len_full} > DEPTH_LIM) begin
                        state_d = FINISH;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    // Bytes shift in from the top so the first byte lands in bits [7:0].
                    word_d     = {byte_data, word_q[23:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    cksum_d    = cksum_q ^ byte_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        state_d       = WRITE;
                        mem_address_d = DATA_WIDTH'({index_q, 2'b00});
                        mem_data_d    = DATA_WIDTH'({byte_data, word_q});
                    end
                end
            end
            WRITE: begin
                index_d = index_q + 16'd1;
                if (index_q + 16'd1 == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = FINISH;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    if (byte_data != cksum_q) begin
                        error_d = 1'b1;
                    end
                    state_d = FINISH;
                end
            end
`endif
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        byte_ready = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA)
`ifdef LOADER_CHECKSUM_EN
                     || (state_q == CHECK)
`endif
                     ;
        mem_write   = (state_q == WRITE);
        done        = (state_q == FINISH);
        busy        = (state_q != IDLE);
        mem_address = mem_address_q;
        mem_data    = mem_data_q;
        error       = error_q;
    end

endmodule
